// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and result bus for seq_divider.
// The caller drives through master; the divider sits on slave.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle and overflow).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
`ifdef SEQ_DIV_SIGNED_EN
    , ST_FIX
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, q_sr, dvs;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             dbz_r;
  logic             busy_c, done_c;
  logic             accept, div0, last;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_step, q_step;
  logic [WIDTH-1:0] op_a, op_b;

  // a + ~b + 1 over WIDTH+1 bits; the top bit of the result is the carry (1 = no borrow).
  // b's extension bit is 0, so its complement is 1 and the carry is a[WIDTH] | low carry.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] lo;
    lo = {1'b0, a[WIDTH-1:0]} + {1'b0, ~b} + (WIDTH + 1)'(1);
    return {a[WIDTH] | lo[WIDTH], lo[WIDTH-1:0]};
  endfunction

`ifdef SEQ_DIV_SIGNED_EN
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic                    sign_q, sign_r, ovf_pend, ovf_r, ovf_det;

  assign dvd_s   = bus.dividend;
  assign dvs_s   = bus.divisor;
  assign ovf_det = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
  assign op_a    = magnitude(dvd_s);
  assign op_b    = magnitude(dvs_s);
  assign bus.overflow = ovf_r;
`else
  assign op_a    = bus.dividend;
  assign op_b    = bus.divisor;
  assign bus.overflow = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && bus.start;
  assign div0   = (bus.divisor == '0);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    rem_sh   = {rem_q, q_sr[WIDTH-1]};
    trial    = trial_sub(rem_sh, dvs);
    rem_step = trial[WIDTH] ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_step   = {q_sr[WIDTH-2:0], trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = div0 ? ST_DONE : ST_RUN;
`ifdef SEQ_DIV_SIGNED_EN
      ST_RUN:  if (last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
`else
      ST_RUN:  if (last) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      ST_RUN:  busy_c = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
      ST_FIX:  busy_c = 1'b1;
`endif
      ST_DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  // Working registers: loaded on accept, stepped in RUN; never observed directly.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q <= '0;
      q_sr  <= op_a;
      dvs   <= op_b;
    end else if (state == ST_RUN) begin
      rem_q <= rem_step;
      q_sr  <= q_step;
    end
  end

  // Result registers change only on entry to DONE (and flags clear on accept).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      ovf_pend <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      dbz_r <= div0;
      if (div0) begin
        quo_r <= '1;
        rem_r <= bus.dividend;
      end
`ifdef SEQ_DIV_SIGNED_EN
      ovf_r    <= 1'b0;
      sign_q   <= dvd_s[WIDTH-1] ^ dvs_s[WIDTH-1];
      sign_r   <= dvd_s[WIDTH-1];
      ovf_pend <= ovf_det;
`endif
    end else if (state == ST_RUN) begin
      cnt <= cnt + CNT_W'(1);
`ifndef SEQ_DIV_SIGNED_EN
      if (last) begin
        quo_r <= q_step;
        rem_r <= rem_step;
      end
`endif
    end
`ifdef SEQ_DIV_SIGNED_EN
    else if (state == ST_FIX) begin
      quo_r <= sign_q ? negate(q_sr) : q_sr;
      rem_r <= sign_r ? negate(rem_q) : rem_q;
      ovf_r <= ovf_pend;
    end
`endif
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider with hand-computed expected results.
// Covers the unsigned build by default and the signed build when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;
  localparam int W = 4;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [W-1:0] prev_q;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request from IDLE; returns with the divider back in IDLE.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
    if (edbz) begin
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".q"}, 32'(bus.quotient), 32'(eq));
      chk({tag, ".r"}, 32'(bus.remainder), 32'(er));
      chk({tag, ".dbz"}, 32'(bus.div_by_zero), 32'd1);
      chk({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
      tick();
      chk({tag, ".done_clr"}, 32'(bus.done), 32'd0);
    end else begin
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".dbz_clr"}, 32'(bus.div_by_zero), 32'd0);
      chk({tag, ".qhold"}, 32'(bus.quotient), 32'(prev_q));
      repeat (LAT - 1) tick();
      chk({tag, ".done_early"}, 32'(bus.done), 32'd0);
      chk({tag, ".busy_late"}, 32'(bus.busy), 32'd1);
      tick();
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
      chk({tag, ".q"}, 32'(bus.quotient), 32'(eq));
      chk({tag, ".r"}, 32'(bus.remainder), 32'(er));
      chk({tag, ".dbz"}, 32'(bus.div_by_zero), 32'd0);
      chk({tag, ".ovf"}, 32'(bus.overflow), 32'(eovf));
      tick();
      chk({tag, ".done_clr"}, 32'(bus.done), 32'd0);
    end
    prev_q = eq;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    prev_q       = '0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.q", 32'(bus.quotient), 32'd0);
    chk("rst.r", 32'(bus.remainder), 32'd0);
    chk("rst.dbz", 32'(bus.div_by_zero), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);

`ifndef SEQ_DIV_SIGNED_EN
    run_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);
    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
    run_div("d2_9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 1'b0);
    run_div("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0);
    run_div("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1'b0);
    run_div("d6_2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0);

    // A second request pulsed during RUN must be dropped.
    bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    chk("ign.done", 32'(bus.done), 32'd1);
    chk("ign.q", 32'(bus.quotient), 32'd4);
    chk("ign.r", 32'(bus.remainder), 32'd1);
    tick();
    chk("ign.idle_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("ign.no_restart", 32'(bus.busy), 32'd0);

    // Start held high: reissue every W+2 cycles.
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    tick();
    chk("b2b.busy0", 32'(bus.busy), 32'd1);
    repeat (4) tick();
    chk("b2b.done0", 32'(bus.done), 32'd1);
    chk("b2b.q0", 32'(bus.quotient), 32'd4);
    tick();
    chk("b2b.gap_busy", 32'(bus.busy), 32'd0);
    chk("b2b.gap_done", 32'(bus.done), 32'd0);
    tick();
    chk("b2b.reissue", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (4) tick();
    chk("b2b.done1", 32'(bus.done), 32'd1);
    tick();
    prev_q = 4'd4;

    // Asynchronous reset in the middle of RUN.
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.done", 32'(bus.done), 32'd0);
    chk("arst.q", 32'(bus.quotient), 32'd0);
    chk("arst.r", 32'(bus.remainder), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    prev_q = '0;
    run_div("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b0);
`else
    run_div("s7_0", 4'b0111, 4'b0000, 4'b1111, 4'b0111, 1'b1, 1'b0);
    run_div("s6_2", 4'b0110, 4'b0010, 4'b0011, 4'b0000, 1'b0, 1'b0);
    run_div("sm7_2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);
    run_div("sm8_m1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1);
    run_div("s7_m2", 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
